// File: rtl/nnrv_pkg.sv
// nnrv_pkg: shared constants for the nnrv RV32I decode stage.
//   - RV32I opcode / funct3 / funct7 encodings
//   - alu_op_e: ALU operation handed to EX
//   - ctrl bundle bit indices and one-hot masks:
//     {reg_we, mem_rd, mem_wr, branch, jump, alu_src_imm}
//   - default datapath widths
package nnrv_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA / SRAI

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam int CTRL_W         = 6;
  localparam int CTRL_REG_WE    = 5;
  localparam int CTRL_MEM_RD    = 4;
  localparam int CTRL_MEM_WR    = 3;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_JUMP      = 1;
  localparam int CTRL_ALU_IMM   = 0;

  localparam logic [CTRL_W-1:0] C_WE  = 6'b100000;
  localparam logic [CTRL_W-1:0] C_MRD = 6'b010000;
  localparam logic [CTRL_W-1:0] C_MWR = 6'b001000;
  localparam logic [CTRL_W-1:0] C_BR  = 6'b000100;
  localparam logic [CTRL_W-1:0] C_JMP = 6'b000010;
  localparam logic [CTRL_W-1:0] C_IMM = 6'b000001;

  // Base (funct7=0) ALU op for an OP / OP-IMM funct3.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/nnrv_id_if.sv
// nnrv_id_if: fetch / write-back / hazard-control inputs and the EX bundle
// of the decode stage.
//   slave  : decode side (consumes i_*, drives o_*)
//   master : environment side (drives i_*, consumes o_*)
interface nnrv_id_if #(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] i_if_instr;
  logic [ADDR_WIDTH-1:0]  i_if_pc;
  logic                   i_stall;
  logic                   i_flush;
  logic                   i_wb_we;
  logic [4:0]             i_wb_rd;
  logic [XLEN-1:0]        i_wb_data;

  logic                   o_ex_valid;
  logic [ADDR_WIDTH-1:0]  o_ex_pc;
  logic [4:0]             o_ex_rd;
  logic [XLEN-1:0]        o_ex_rs1_val;
  logic [XLEN-1:0]        o_ex_rs2_val;
  logic [XLEN-1:0]        o_ex_imm;
  logic [3:0]             o_ex_alu_op;
  logic [5:0]             o_ex_ctrl;
  logic                   o_ex_illegal;

  modport slave (
    input  i_if_instr, i_if_pc, i_stall, i_flush, i_wb_we, i_wb_rd, i_wb_data,
    output o_ex_valid, o_ex_pc, o_ex_rd, o_ex_rs1_val, o_ex_rs2_val,
           o_ex_imm, o_ex_alu_op, o_ex_ctrl, o_ex_illegal
  );

  modport master (
    output i_if_instr, i_if_pc, i_stall, i_flush, i_wb_we, i_wb_rd, i_wb_data,
    input  o_ex_valid, o_ex_pc, o_ex_rd, o_ex_rs1_val, o_ex_rs2_val,
           o_ex_imm, o_ex_alu_op, o_ex_ctrl, o_ex_illegal
  );
endinterface

// File: rtl/nnrv_regfile.sv
// nnrv_regfile: integer register file, x0 hardwired to zero.
//   i_clk, i_rst_n     : clock, synchronous active-low clear of x1..x(NREGS-1)
//   i_we/i_waddr/i_wdata : write port, committed at the rising edge
//   i_raddr1/2, o_rdata1/2 : combinational read ports
// Optional macro NNRV_ID_WB_BYPASS_EN: forward a same-cycle write to the
// read ports instead of returning the pre-write value.
module nnrv_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_en;

  assign wr_en = i_we && (i_waddr != 5'd0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? '0 : regs[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? '0 : regs[i_raddr2];
`ifdef NNRV_ID_WB_BYPASS_EN
    // x0 is excluded through wr_en, so a bypassed x0 read stays zero
    if (wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`endif
  end

endmodule

// File: rtl/nnrv_id.sv
// nnrv_id: RV32I instruction decode stage.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : fetch instr/pc, stall/flush, WB write port in;
//                    registered EX decode bundle out (1-cycle latency)
// Optional macro NNRV_ID_WB_BYPASS_EN (in nnrv_regfile): same-cycle WB
// write forwarded to the operand reads.
module nnrv_id
  import nnrv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int NREGS       = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  nnrv_id_if.slave  bus
);

  logic [INSTR_WIDTH-1:0] instr;
  logic [6:0]             f_opc, f_f7;
  logic [2:0]             f_f3;
  logic [4:0]             f_rd, f_rs1, f_rs2;
  logic [31:0]            imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = bus.i_if_instr;
  assign f_opc = instr[6:0];
  assign f_rd  = instr[11:7];
  assign f_f3  = instr[14:12];
  assign f_rs1 = instr[19:15];
  assign f_rs2 = instr[24:20];
  assign f_f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // ---- decode ----
  logic              d_valid, d_ill, use1, use2;
  logic [4:0]        d_rd, d_rs1, d_rs2;
  logic [31:0]       d_imm32;
  logic [XLEN-1:0]   d_imm;
  logic [CTRL_W-1:0] d_ctrl;
  alu_op_e           d_alu;

  assign d_valid = |instr;

  always_comb begin
    d_ill   = 1'b0;
    d_alu   = ALU_ADD;
    d_ctrl  = '0;
    d_imm32 = '0;
    d_rd    = f_rd;
    use1    = 1'b0;
    use2    = 1'b0;
    case (f_opc)
      OPC_LUI: begin
        d_imm32 = imm_u; d_alu = ALU_PASSB; d_ctrl = C_WE | C_IMM;
      end
      OPC_AUIPC: begin
        d_imm32 = imm_u; d_ctrl = C_WE | C_IMM;
      end
      OPC_JAL: begin
        d_imm32 = imm_j; d_ctrl = C_WE | C_JMP;
      end
      OPC_JALR: begin
        d_imm32 = imm_i; d_ctrl = C_WE | C_JMP | C_IMM; use1 = 1'b1;
        d_ill   = (f_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_imm32 = imm_b; d_ctrl = C_BR; d_rd = 5'd0; use1 = 1'b1; use2 = 1'b1;
        case (f_f3)
          3'b000, 3'b001: d_alu = ALU_SUB;   // beq / bne
          3'b100, 3'b101: d_alu = ALU_SLT;   // blt / bge
          3'b110, 3'b111: d_alu = ALU_SLTU;  // bltu / bgeu
          default:        d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_imm32 = imm_i; d_ctrl = C_WE | C_MRD | C_IMM; use1 = 1'b1;
        d_ill   = (f_f3 == 3'b011) || (f_f3 == 3'b110) || (f_f3 == 3'b111);
      end
      OPC_STORE: begin
        d_imm32 = imm_s; d_ctrl = C_MWR | C_IMM; d_rd = 5'd0;
        use1    = 1'b1; use2 = 1'b1;
        d_ill   = (f_f3 > 3'b010);
      end
      OPC_OPIMM: begin
        d_ctrl = C_WE | C_IMM; use1 = 1'b1;
        d_alu  = alu_from_f3(f_f3);
        if (f_f3 == F3_SLL || f_f3 == F3_SR) begin
          // shift-immediates carry only the shamt; funct7 lives in imm[11:5]
          d_imm32 = {27'b0, instr[24:20]};
          if (f_f3 == F3_SR && f_f7 == F7_ALT) d_alu = ALU_SRA;
          else if (f_f7 != F7_BASE)            d_ill = 1'b1;
        end else begin
          d_imm32 = imm_i;
        end
      end
      OPC_OP: begin
        d_ctrl = C_WE; use1 = 1'b1; use2 = 1'b1;
        if (f_f7 == F7_BASE)                         d_alu = alu_from_f3(f_f3);
        else if (f_f7 == F7_ALT && f_f3 == F3_ADD)   d_alu = ALU_SUB;
        else if (f_f7 == F7_ALT && f_f3 == F3_SR)    d_alu = ALU_SRA;
        else                                         d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase

    if (d_ill || !d_valid) begin
      d_ctrl  = '0;
      d_rd    = 5'd0;
      d_imm32 = '0;
      d_alu   = ALU_ADD;
      use1    = 1'b0;
      use2    = 1'b0;
    end
    if (!d_valid) d_ill = 1'b0;  // all-zero word is a bubble, not illegal
  end

  assign d_imm = XLEN'($signed(d_imm32));
  // unused source fields read as x0, i.e. zero
  assign d_rs1 = use1 ? f_rs1 : 5'd0;
  assign d_rs2 = use2 ? f_rs2 : 5'd0;

  // ---- register file ----
  // During a stall the held source indices are re-read every cycle so a
  // write-back landing mid-stall reaches the held bundle.
  logic [4:0]      rs1_q, rs2_q, ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;

  assign ra1 = bus.i_stall ? rs1_q : d_rs1;
  assign ra2 = bus.i_stall ? rs2_q : d_rs2;

  nnrv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (bus.i_wb_we),
    .i_waddr  (bus.i_wb_rd),
    .i_wdata  (bus.i_wb_data),
    .i_raddr1 (ra1),
    .i_raddr2 (ra2),
    .o_rdata1 (rd1),
    .o_rdata2 (rd2)
  );

  // ---- EX pipeline register ----
  logic              ex_valid, ex_ill;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic [4:0]        ex_rd;
  logic [XLEN-1:0]   ex_rs1, ex_rs2, ex_imm;
  logic [3:0]        ex_alu;
  logic [CTRL_W-1:0] ex_ctrl;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) begin
      ex_valid <= 1'b0;
      ex_ill   <= 1'b0;
      ex_pc    <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_imm   <= '0;
      ex_alu   <= '0;
      ex_ctrl  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (bus.i_stall) begin
      ex_rs1 <= rd1;
      ex_rs2 <= rd2;
    end else begin
      ex_valid <= d_valid;
      ex_ill   <= d_ill;
      ex_pc    <= d_valid ? bus.i_if_pc : '0;
      ex_rd    <= d_rd;
      ex_rs1   <= rd1;
      ex_rs2   <= rd2;
      ex_imm   <= d_imm;
      ex_alu   <= d_alu;
      ex_ctrl  <= d_ctrl;
      rs1_q    <= d_rs1;
      rs2_q    <= d_rs2;
    end
  end

  assign bus.o_ex_valid   = ex_valid;
  assign bus.o_ex_pc      = ex_pc;
  assign bus.o_ex_rd      = ex_rd;
  assign bus.o_ex_rs1_val = ex_rs1;
  assign bus.o_ex_rs2_val = ex_rs2;
  assign bus.o_ex_imm     = ex_imm;
  assign bus.o_ex_alu_op  = ex_alu;
  assign bus.o_ex_ctrl    = ex_ctrl;
  assign bus.o_ex_illegal = ex_ill;

endmodule

// File: tb/tb_nnrv_id.sv
// tb_nnrv_id: directed vectors for nnrv_id; expected bundles go into a
// queue, a monitor on the falling edge pops and compares each one.
module tb_nnrv_id;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nnrv_id_if bus ();

  nnrv_id dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

`ifdef NNRV_ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        valid;
    logic [7:0]  pc;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [5:0]  ctrl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // alu op codes / ctrl masks written out by hand
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASSB = 4'd10;
  localparam logic [5:0] WE = 6'b100000, MRD = 6'b010000, MWR = 6'b001000,
                         BR = 6'b000100, JMP = 6'b000010, IMM = 6'b000001;

  function automatic exp_t mk(input logic v, input logic [7:0] pc, input logic [4:0] rd,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic [5:0] ctrl, input logic ill);
    exp_t e;
    e.id = 0; e.valid = v; e.pc = pc; e.rd = rd; e.rs1 = r1; e.rs2 = r2;
    e.imm = imm; e.alu = alu; e.ctrl = ctrl; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string n, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%h expected=%h", n, id, act, exp);
    end
  endtask

  // drive on the falling edge, queue the bundle expected after the rising edge
  task automatic step(input logic rst, input logic [31:0] instr, input logic [7:0] pc,
                      input logic stall, input logic flush, input logic we,
                      input logic [4:0] wrd, input logic [31:0] wdata, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst_n             = rst;
    bus.i_if_instr    = instr;
    bus.i_if_pc       = pc;
    bus.i_stall       = stall;
    bus.i_flush       = flush;
    bus.i_wb_we       = we;
    bus.i_wb_rd       = wrd;
    bus.i_wb_data     = wdata;
    @(posedge clk);
    #1;
    x    = e;
    x.id = step_id++;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid",   e.id, {31'b0, bus.o_ex_valid},   {31'b0, e.valid});
        chk("pc",      e.id, {24'b0, bus.o_ex_pc},      {24'b0, e.pc});
        chk("rd",      e.id, {27'b0, bus.o_ex_rd},      {27'b0, e.rd});
        chk("rs1_val", e.id, bus.o_ex_rs1_val,          e.rs1);
        chk("rs2_val", e.id, bus.o_ex_rs2_val,          e.rs2);
        chk("imm",     e.id, bus.o_ex_imm,              e.imm);
        chk("alu_op",  e.id, {28'b0, bus.o_ex_alu_op},  {28'b0, e.alu});
        chk("ctrl",    e.id, {26'b0, bus.o_ex_ctrl},    {26'b0, e.ctrl});
        chk("illegal", e.id, {31'b0, bus.o_ex_illegal}, {31'b0, e.ill});
      end
    end
  end

  initial begin : driver
    exp_t z;
    z = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    bus.i_if_instr = '0; bus.i_if_pc = '0; bus.i_stall = 0; bus.i_flush = 0;
    bus.i_wb_we = 0; bus.i_wb_rd = '0; bus.i_wb_data = '0;

    // 0-1: reset, with a live instruction and stall present
    step(0, 32'h00500093, 8'h04, 1, 0, 1, 5'd1, 32'h55, z);
    step(0, 32'h00500093, 8'h04, 0, 0, 0, 5'd0, 32'h0,  z);
    // 2: addi x1,x0,5
    step(1, 32'h00500093, 8'h04, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h04, 1, 0, 0, 32'd5, A_ADD, WE | IMM, 0));
    // 3-4: bubbles while WB fills x1=5, x2=7
    step(1, 32'h0, 8'h00, 0, 0, 1, 5'd1, 32'd5, z);
    step(1, 32'h0, 8'h00, 0, 0, 1, 5'd2, 32'd7, z);
    // 5: add x3,x1,x2
    step(1, 32'h002081B3, 8'h08, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h08, 3, 32'd5, 32'd7, 0, A_ADD, WE, 0));
    // 6: lw x5,8(x2)
    step(1, 32'h00812283, 8'h0C, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h0C, 5, 32'd7, 0, 32'd8, A_ADD, WE | MRD | IMM, 0));
    // 7-9: stall 3 cycles, different instr on the input, x2=0x100 in stall cycle 2
    step(1, 32'h002081B3, 8'h10, 1, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h0C, 5, 32'd7, 0, 32'd8, A_ADD, WE | MRD | IMM, 0));
    step(1, 32'h002081B3, 8'h10, 1, 0, 1, 5'd2, 32'h100,
         mk(1, 8'h0C, 5, BYP ? 32'h100 : 32'd7, 0, 32'd8, A_ADD, WE | MRD | IMM, 0));
    step(1, 32'h002081B3, 8'h10, 1, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h0C, 5, 32'h100, 0, 32'd8, A_ADD, WE | MRD | IMM, 0));
    // 10: all-ones word is illegal but valid
    step(1, 32'hFFFFFFFF, 8'h14, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h14, 0, 0, 0, 0, A_ADD, 0, 1));
    // 11: flush beats stall
    step(1, 32'h00500093, 8'h18, 1, 1, 0, 5'd0, 32'h0, z);
    // 12: beq x0,x0,-4 with a WB write to x0
    step(1, 32'hFE000EE3, 8'h18, 0, 0, 1, 5'd0, 32'hDEAD,
         mk(1, 8'h18, 0, 0, 0, 32'hFFFFFFFC, A_SUB, BR, 0));
    // 13: add x7,x0,x0 -> x0 still reads zero
    step(1, 32'h000003B3, 8'h1C, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h1C, 7, 0, 0, 0, A_ADD, WE, 0));
    // 14: addi x6,x4,0 with same-cycle WB x4=9
    step(1, 32'h00020313, 8'h20, 0, 0, 1, 5'd4, 32'd9,
         mk(1, 8'h20, 6, BYP ? 32'd9 : 32'd0, 0, 0, A_ADD, WE | IMM, 0));
    // 15: same instruction again, write now visible either way
    step(1, 32'h00020313, 8'h24, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h24, 6, 32'd9, 0, 0, A_ADD, WE | IMM, 0));
    // 16: lui x8,0x12345
    step(1, 32'h12345437, 8'h28, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h28, 8, 0, 0, 32'h12345000, A_PASSB, WE | IMM, 0));
    // 17: sw x1,-4(x2)
    step(1, 32'hFE112E23, 8'h2C, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h2C, 0, 32'h100, 32'd5, 32'hFFFFFFFC, A_ADD, MWR | IMM, 0));
    // 18: jal x1,8
    step(1, 32'h008000EF, 8'h30, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h30, 1, 0, 0, 32'd8, A_ADD, WE | JMP, 0));
    // 19: srai x9,x1,3
    step(1, 32'h4030D493, 8'h34, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h34, 9, 32'd5, 0, 32'd3, A_SRA, WE | IMM, 0));
    // 20: slli with funct7=0100000 is illegal
    step(1, 32'h40309493, 8'h38, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h38, 0, 0, 0, 0, A_ADD, 0, 1));
    // 21: sub x10,x1,x2
    step(1, 32'h40208533, 8'h3C, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h3C, 10, 32'd5, 32'h100, 0, A_SUB, WE, 0));
    // 22: fence is unsupported
    step(1, 32'h0000000F, 8'h40, 0, 0, 0, 5'd0, 32'h0,
         mk(1, 8'h40, 0, 0, 0, 0, A_ADD, 0, 1));
    // 23: bubble
    step(1, 32'h0, 8'h44, 0, 0, 0, 5'd0, 32'h0, z);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending bundles", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
